branch_npc_unit: RTL and testbench
==================================

Name: branch_npc_unit

Overview:
- Resolves ID-stage branches and jumps from the register comparator flags, and owns the architectural fetch PC register.
- Consumes the comparator's unequal flag and its zero/negative/positive class, plus decode fields, and produces the next fetch address.
- Implements the MIPS one-instruction delay slot, exception/ERET redirect, a pending-redirect buffer for a stalled fetch stage, and a taken-branch counter.
- Sits between the ID-stage comparator/decoder and the IF stage / instruction memory.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch address loaded on reset
CNT_W, 32, width of taken-branch counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc_wr_en  in  1  IF can accept a new PC this cycle (0 = fetch stalled)
id_fire  in  1  instruction in ID is valid and leaves ID this cycle
br_type  in  4  0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J, 8 JAL, 9 JR, 10 JALR, others = none
cmp_neq  in  1  1 = rs != rt
cmp_cls  in  2  rs class: 00 zero, 01 positive, 10 negative (11 treated as positive)
id_pc  in  32  PC of instruction in ID
imm16  in  16  branch offset
instr_index  in  26  J/JAL target field
gpr_rs  in  32  forwarded rs value (JR/JALR target)
exc_redirect  in  1  exception taken, redirect to exc_pc
exc_pc  in  32  exception vector
eret  in  1  ERET commit, redirect to epc
epc  in  32  return address
pc  out  32  current fetch address (register)
if_in_ds  out  1  instruction fetched at pc is a branch delay slot (register)
br_taken  out  1  combinational: ID control transfer taken this cycle
link_addr  out  32  combinational: id_pc + 8
jr_addr_err  out  1  registered one-cycle pulse: taken JR/JALR target[1:0] != 0
taken_cnt  out  CNT_W  number of taken control transfers since reset, wraps

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, if_in_ds=0, jr_addr_err=0, taken_cnt=0, state=RUN, pending cleared. Reset overrides every other input.
- Taken condition (only when id_fire=1):
  - BEQ: cmp_neq==0. BNE: cmp_neq==1.
  - BLEZ: cls!=01. BGTZ: cls==01. BLTZ: cls==10. BGEZ: cls!=10.
  - J/JAL/JR/JALR: always.
- br_taken=0 when id_fire=0.
- Targets, all mod 2^32:
  - Branch: id_pc + 4 + (sign-extended imm16 << 2).
  - J/JAL: {id_pc_plus4[31:28], instr_index, 2'b00}.
  - JR/JALR: gpr_rs, unmodified.
- The delay slot is already in IF when the branch is in ID, so the taken target becomes the next pc directly. Zero-cycle resolution penalty.
- States:
  - RUN: normal operation.
  - PEND: a taken target is buffered (tgt_q) because IF was stalled.
- Priority per cycle, highest first:
  1. rst.
  2. exc_redirect, using exc_pc (exc_redirect beats eret if both are asserted): pc=redirect address regardless of pc_wr_en, if_in_ds=0, state=RUN, pending discarded.
  3. eret, using epc: same as item 2.
  4. PEND with pc_wr_en=1: pc=tgt_q, state=RUN, if_in_ds=0.
  5. pc_wr_en=0: pc holds. If RUN and taken, then tgt_q=target and state=PEND. A second taken while in PEND is a protocol violation; the latest target overwrites.
  6. RUN, pc_wr_en=1, taken: pc=target, if_in_ds=0.
  7. RUN, pc_wr_en=1, not taken: pc=pc+4. if_in_ds=1 iff id_fire and br_type is not none (a not-taken branch still has a delay slot); else 0.
- if_in_ds extra rule: when a branch fires while IF is stalled, if_in_ds is set on the stalled cycle and held until pc advances.
- taken_cnt increments by 1 on every taken event, including those captured into PEND. It does not increment on a redirect. It wraps from all-ones to 0.
- jr_addr_err: asserted for one cycle after a taken JR/JALR with gpr_rs[1:0]!=0. The redirect still occurs; the exception unit handles the fault.
- link_addr is valid whenever id_fire=1; it is the write data for JAL/JALR.

Test Plan:
1. Reset: rst=1 for 2 cycles, then pc_wr_en=1, no branches -> pc sequence BFC00000, BFC00004, BFC00008; taken_cnt=0; if_in_ds=0.
2. BEQ taken: id_pc=0x1000, imm16=0xFFFE, cmp_neq=0, id_fire=1 -> br_taken=1, next pc=0x0FFC, taken_cnt=1, link_addr=0x1008. Repeat with cmp_neq=1 -> pc=pc+4 and if_in_ds=1.
3. Class branches: cmp_cls=00/01/10 across BLEZ/BGTZ/BLTZ/BGEZ -> taken patterns 1/0/1, 0/1/0, 0/0/1, 1/1/0 respectively.
4. Stalled IF: JR with gpr_rs=0x2000, pc_wr_en=0 for 3 cycles -> pc held, state PEND; pc_wr_en=1 -> pc=0x2000 on the next edge, taken_cnt +1 exactly once.
5. Redirect priority: in PEND, assert exc_redirect=1 with exc_pc=0x80000180 and eret=1 in the same cycle -> pc=0x80000180, pending dropped; later pc_wr_en=1 does not load the old target.
6. JR misaligned (gpr_rs=0x2002) -> pc=0x2002, jr_addr_err high for exactly one cycle. Counter wrap with CNT_W=4: 16 taken branches -> taken_cnt=0.

Source files
------------

// File: rtl/branch_npc_unit_if.sv
// ID-to-fetch control bundle for branch_npc_unit.
// Master is the ID/exception side; slave is the NPC unit.
interface branch_npc_unit_if #(
    parameter int CNT_W = 32
);
    logic             pc_wr_en;
    logic             id_fire;
    logic [3:0]       br_type;
    logic             cmp_neq;
    logic [1:0]       cmp_cls;
    logic [31:0]      id_pc;
    logic [15:0]      imm16;
    logic [25:0]      instr_index;
    logic [31:0]      gpr_rs;
    logic             exc_redirect;
    logic [31:0]      exc_pc;
    logic             eret;
    logic [31:0]      epc;
    logic [31:0]      pc;
    logic             if_in_ds;
    logic             br_taken;
    logic [31:0]      link_addr;
    logic             jr_addr_err;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output pc_wr_en, id_fire, br_type, cmp_neq, cmp_cls,
        output id_pc, imm16, instr_index, gpr_rs,
        output exc_redirect, exc_pc, eret, epc,
        input  pc, if_in_ds, br_taken, link_addr,
        input  jr_addr_err, taken_cnt
    );

    modport slave (
        input  pc_wr_en, id_fire, br_type, cmp_neq, cmp_cls,
        input  id_pc, imm16, instr_index, gpr_rs,
        input  exc_redirect, exc_pc, eret, epc,
        output pc, if_in_ds, br_taken, link_addr,
        output jr_addr_err, taken_cnt
    );
endinterface

// File: rtl/branch_npc_unit.sv
// ID-stage branch resolution and fetch PC owner.
// Delay-slot aware, with a pending-target buffer for a stalled IF.
module branch_npc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          CNT_W    = 32
) (
    input logic              clk,
    input logic              rst,
    branch_npc_unit_if.slave bus
);
    typedef enum logic {RUN, PEND} state_t;

    localparam logic [3:0] BT_BEQ  = 4'd1;
    localparam logic [3:0] BT_BNE  = 4'd2;
    localparam logic [3:0] BT_BLEZ = 4'd3;
    localparam logic [3:0] BT_BGTZ = 4'd4;
    localparam logic [3:0] BT_BLTZ = 4'd5;
    localparam logic [3:0] BT_BGEZ = 4'd6;
    localparam logic [3:0] BT_J    = 4'd7;
    localparam logic [3:0] BT_JAL  = 4'd8;
    localparam logic [3:0] BT_JR   = 4'd9;
    localparam logic [3:0] BT_JALR = 4'd10;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      tgt_q, tgt_d;
    logic             ds_q, ds_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      id_plus4, pc_plus4;
    logic [31:0]      br_tgt, j_tgt, target;
    logic             cond, is_br, is_jr;
    logic             taken, redir, cls_pos, cls_neg;

    assign id_plus4 = bus.id_pc + 32'd4;
    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = id_plus4
                    + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign j_tgt    = {id_plus4[31:28], bus.instr_index, 2'b00};
    assign redir    = bus.exc_redirect | bus.eret;
    // Class 11 is folded into positive.
    assign cls_pos  = bus.cmp_cls[0];
    assign cls_neg  = (bus.cmp_cls == 2'b10);

    always_comb begin
        cond   = 1'b0;
        is_br  = 1'b1;
        is_jr  = 1'b0;
        target = br_tgt;
        case (bus.br_type)
            BT_BEQ:  cond = !bus.cmp_neq;
            BT_BNE:  cond = bus.cmp_neq;
            BT_BLEZ: cond = !cls_pos;
            BT_BGTZ: cond = cls_pos;
            BT_BLTZ: cond = cls_neg;
            BT_BGEZ: cond = !cls_neg;
            BT_J, BT_JAL: begin
                cond   = 1'b1;
                target = j_tgt;
            end
            BT_JR, BT_JALR: begin
                cond   = 1'b1;
                is_jr  = 1'b1;
                target = bus.gpr_rs;
            end
            default: is_br = 1'b0;
        endcase
    end

    assign taken = bus.id_fire & cond;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redir)
            state_d = RUN;
        else if (state_q == PEND) begin
            if (bus.pc_wr_en) state_d = RUN;
        end else if (!bus.pc_wr_en && taken)
            state_d = PEND;
    end

    always_comb begin
        pc_d  = pc_q;
        ds_d  = ds_q;
        tgt_d = tgt_q;
        err_d = taken & is_jr & (|bus.gpr_rs[1:0]);
        if (bus.exc_redirect) begin
            pc_d = bus.exc_pc;
            ds_d = 1'b0;
        end else if (bus.eret) begin
            pc_d = bus.epc;
            ds_d = 1'b0;
        end else if (state_q == PEND && bus.pc_wr_en) begin
            pc_d = tgt_q;
            ds_d = 1'b0;
        end else if (!bus.pc_wr_en) begin
            // Stalled: remember the slot flag and the latest target.
            ds_d = ds_q | (bus.id_fire & is_br);
            if (taken) tgt_d = target;
        end else if (taken) begin
            pc_d = target;
            ds_d = 1'b0;
        end else begin
            pc_d = pc_plus4;
            ds_d = bus.id_fire & is_br;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ds_q  <= 1'b0;
            tgt_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ds_q  <= ds_d;
            tgt_q <= tgt_d;
            err_q <= err_d;
            if (taken && !redir) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.if_in_ds    = ds_q;
    assign bus.br_taken    = taken;
    assign bus.link_addr   = bus.id_pc + 32'd8;
    assign bus.jr_addr_err = err_q;
    assign bus.taken_cnt   = cnt_q;
endmodule

// File: tb/tb_branch_npc_unit.sv
// Scoreboard bench for branch_npc_unit.
// Expected state is queued on drive and popped after the edge.
module tb_branch_npc_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic        ds;
        logic [3:0]  cnt;
        logic        err;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    st_t  sb[$];
    st_t  a, e;
    logic [31:0] exp_pc;
    logic [3:0]  exp_cnt;

    always #5 clk = ~clk;

    branch_npc_unit_if #(.CNT_W(4)) bif();

    branch_npc_unit #(
        .RESET_PC(32'hBFC0_0000),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    task automatic idle();
        bif.pc_wr_en     = 1'b1;
        bif.id_fire      = 1'b0;
        bif.br_type      = 4'd0;
        bif.cmp_neq      = 1'b0;
        bif.cmp_cls      = 2'b00;
        bif.id_pc        = 32'h0;
        bif.imm16        = 16'h0;
        bif.instr_index  = 26'h0;
        bif.gpr_rs       = 32'h0;
        bif.exc_redirect = 1'b0;
        bif.exc_pc       = 32'h0;
        bif.eret         = 1'b0;
        bif.epc          = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic d,
                        input logic er);
        st_t x;
        x.pc  = p;
        x.ds  = d;
        x.cnt = exp_cnt;
        x.err = er;
        sb.push_back(x);
        exp_pc = p;
    endtask

    function automatic st_t snap();
        st_t s;
        s.pc  = bif.pc;
        s.ds  = bif.if_in_ds;
        s.cnt = bif.taken_cnt;
        s.err = bif.jr_addr_err;
        return s;
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b1;
        exp_cnt = 4'd0;
        tick();
        push(32'hBFC0_0000, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL reset act pc=%h ds=%b cnt=%0d err=%b req pc=%h ds=%b cnt=%0d err=%b",
                     a.pc, a.ds, a.cnt, a.err, e.pc, e.ds, e.cnt, e.err);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(exp_pc + 32'd4, 1'b0, 1'b0);
            tick();
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL seq%0d act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                         i, a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
            end
        end
    endtask

    task automatic test_beq();
        idle();
        bif.br_type = 4'd1;
        bif.id_pc   = 32'h1000;
        bif.imm16   = 16'hFFFE;
        #1;
        checks++;
        if (bif.br_taken !== 1'b0) begin
            errors++;
            $display("FAIL beq_nofire act taken=%b req 0", bif.br_taken);
        end
        bif.id_fire = 1'b1;
        #1;
        checks++;
        if (bif.br_taken !== 1'b1 || bif.link_addr !== 32'h1008) begin
            errors++;
            $display("FAIL beq_comb act taken=%b link=%h req 1 00001008",
                     bif.br_taken, bif.link_addr);
        end
        exp_cnt++;
        push(32'h0000_0FFC, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL beq_taken act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                     a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
        end
        bif.cmp_neq = 1'b1;
        #1;
        checks++;
        if (bif.br_taken !== 1'b0) begin
            errors++;
            $display("FAIL beq_nt_comb act taken=%b req 0", bif.br_taken);
        end
        push(exp_pc + 32'd4, 1'b1, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL beq_nt act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                     a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
        end
    endtask

    task automatic test_class();
        logic [2:0] pat [4];
        logic       tk;
        pat[0] = 3'b101;
        pat[1] = 3'b010;
        pat[2] = 3'b100;
        pat[3] = 3'b011;
        idle();
        bif.id_fire = 1'b1;
        bif.id_pc   = 32'h4000;
        bif.imm16   = 16'h0010;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 3; c++) begin
                bif.br_type = 4'(3 + t);
                bif.cmp_cls = 2'(c);
                tk = pat[t][c];
                #1;
                checks++;
                if (bif.br_taken !== tk) begin
                    errors++;
                    $display("FAIL cls_t%0d_c%0d act taken=%b req %b",
                             t + 3, c, bif.br_taken, tk);
                end
                if (tk) begin
                    exp_cnt++;
                    push(32'h4044, 1'b0, 1'b0);
                end else begin
                    push(exp_pc + 32'd4, 1'b1, 1'b0);
                end
                tick();
                e = sb.pop_front(); a = snap(); checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cls_st%0d_%0d act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                             t + 3, c, a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
                end
            end
        end
        bif.br_type = 4'd4;
        bif.cmp_cls = 2'b11;
        #1;
        checks++;
        if (bif.br_taken !== 1'b1) begin
            errors++;
            $display("FAIL bgtz_cls11 act taken=%b req 1", bif.br_taken);
        end
        exp_cnt++;
        push(32'h4044, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL bgtz_cls11_st act pc=%h cnt=%0d req pc=%h cnt=%0d",
                     a.pc, a.cnt, e.pc, e.cnt);
        end
    endtask

    task automatic test_jump();
        idle();
        bif.id_fire     = 1'b1;
        bif.br_type     = 4'd8;
        bif.id_pc       = 32'h9000_1000;
        bif.instr_index = 26'h012_3456;
        #1;
        checks++;
        if (bif.br_taken !== 1'b1 || bif.link_addr !== 32'h9000_1008) begin
            errors++;
            $display("FAIL jal_comb act taken=%b link=%h req 1 90001008",
                     bif.br_taken, bif.link_addr);
        end
        exp_cnt++;
        push(32'h9048_D158, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL jal_tgt act pc=%h cnt=%0d req pc=%h cnt=%0d",
                     a.pc, a.cnt, e.pc, e.cnt);
        end
    endtask

    task automatic test_stall();
        idle();
        bif.pc_wr_en = 1'b0;
        bif.id_fire  = 1'b1;
        bif.br_type  = 4'd9;
        bif.gpr_rs   = 32'h2000;
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            push(exp_pc, 1'b1, 1'b0);
            tick();
            bif.id_fire = 1'b0;
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL stall%0d act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                         i, a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
            end
        end
        bif.pc_wr_en = 1'b1;
        push(32'h2000, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL stall_release act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                     a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
        end
    endtask

    task automatic test_redirect();
        idle();
        bif.pc_wr_en = 1'b0;
        bif.id_fire  = 1'b1;
        bif.br_type  = 4'd9;
        bif.gpr_rs   = 32'h3000;
        exp_cnt++;
        push(exp_pc, 1'b1, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL redir_pend act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                     a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
        end
        idle();
        bif.pc_wr_en     = 1'b0;
        bif.exc_redirect = 1'b1;
        bif.exc_pc       = 32'h8000_0180;
        bif.eret         = 1'b1;
        bif.epc          = 32'h1234_5678;
        push(32'h8000_0180, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL exc_prio act pc=%h ds=%b cnt=%0d req pc=%h ds=%b cnt=%0d",
                     a.pc, a.ds, a.cnt, e.pc, e.ds, e.cnt);
        end
        idle();
        push(32'h8000_0184, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL pend_drop act pc=%h req pc=%h", a.pc, e.pc);
        end
        bif.pc_wr_en = 1'b0;
        bif.eret     = 1'b1;
        bif.epc      = 32'h0040_0000;
        push(32'h0040_0000, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL eret act pc=%h cnt=%0d req pc=%h cnt=%0d",
                     a.pc, a.cnt, e.pc, e.cnt);
        end
        idle();
    endtask

    task automatic test_jr_misaligned();
        idle();
        bif.id_fire = 1'b1;
        bif.br_type = 4'd10;
        bif.id_pc   = 32'h5000;
        bif.gpr_rs  = 32'h2002;
        #1;
        checks++;
        if (bif.br_taken !== 1'b1 || bif.link_addr !== 32'h5008) begin
            errors++;
            $display("FAIL jalr_comb act taken=%b link=%h req 1 00005008",
                     bif.br_taken, bif.link_addr);
        end
        exp_cnt++;
        push(32'h2002, 1'b0, 1'b1);
        tick();
        idle();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL jr_err_set act pc=%h err=%b cnt=%0d req pc=%h err=%b cnt=%0d",
                     a.pc, a.err, a.cnt, e.pc, e.err, e.cnt);
        end
        push(32'h2006, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL jr_err_clr act pc=%h err=%b req pc=%h err=%b",
                     a.pc, a.err, e.pc, e.err);
        end
    endtask

    task automatic test_wrap();
        idle();
        bif.id_fire = 1'b1;
        bif.br_type = 4'd7;
        bif.id_pc   = 32'h100;
        rst = 1'b1;
        exp_cnt = 4'd0;
        push(32'hBFC0_0000, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL rst_override act pc=%h cnt=%0d req pc=%h cnt=%0d",
                     a.pc, a.cnt, e.pc, e.cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bif.instr_index = 26'(i + 1);
            exp_cnt++;
            push(32'((i + 1) * 4), 1'b0, 1'b0);
            tick();
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL wrap%0d act pc=%h cnt=%0d req pc=%h cnt=%0d",
                         i, a.pc, a.cnt, e.pc, e.cnt);
            end
        end
        checks++;
        if (bif.taken_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_zero act cnt=%0d req 0", bif.taken_cnt);
        end
        idle();
    endtask

    initial begin
        exp_pc  = 32'h0;
        exp_cnt = 4'd0;
        test_reset();
        test_beq();
        test_class();
        test_jump();
        test_stall();
        test_redirect();
        test_jr_misaligned();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
